// File: rtl/vpu_unit_if.sv
// Shared request/response types and the core-side handshake interface of the
// vector processing unit.
package vpu_unit_pkg;
   localparam int unsigned MAX_VECTOR_LENGTH = 8;
   localparam int unsigned DATA_W            = 32;

   typedef logic [MAX_VECTOR_LENGTH-1:0][DATA_W-1:0] vec_t;

   typedef enum logic [3:0] {
      OP_ADD        = 4'd0,
      OP_SUB        = 4'd1,
      OP_MUL        = 4'd2,
      OP_DIV        = 4'd3,
      OP_LOAD       = 4'd4,
      OP_STORE      = 4'd5,
      OP_REDUCE_SUM = 4'd6,
      OP_REDUCE_MIN = 4'd7,
      OP_REDUCE_MAX = 4'd8,
      OP_PERMUTE    = 4'd9
   } vpu_op_e;

   typedef struct packed {
      logic              valid;
      logic [3:0]        opcode;
      logic [31:0]       vector_length;
      logic [31:0]       addr;
      vec_t              operand1_vector;
      vec_t              operand2_vector;
   } vpu_req_t;

   typedef struct packed {
      logic              valid;
      vec_t              result_vector;
      logic              error;
   } vpu_rsp_t;
endpackage

interface vpu_unit_if;
   import vpu_unit_pkg::*;

   vpu_req_t vpu_req_i;
   logic     vpu_req_ready_o;
   vpu_rsp_t vpu_rsp_o;
   logic     vpu_rsp_ready_i;

   modport master (
      output vpu_req_i,
      output vpu_rsp_ready_i,
      input  vpu_req_ready_o,
      input  vpu_rsp_o
   );

   modport slave (
      input  vpu_req_i,
      input  vpu_rsp_ready_i,
      output vpu_req_ready_o,
      output vpu_rsp_o
   );
endinterface

// File: rtl/vpu_unit.sv
// Multi-cycle vector unit: element-wise arithmetic, reductions, permute and
// load/store against a private word-addressed memory, one element per cycle.
module vpu_unit
   import vpu_unit_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic       clk_i,
   input  logic       rst_i,
   vpu_unit_if.slave  bus
);

   localparam int unsigned IDX_W  = $clog2(MAX_VECTOR_LENGTH);
   localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t             state;
   logic [3:0]         opcode_q;
   logic [31:0]        vl_q;
   logic [31:0]        addr_q;
   vec_t               op1_q;
   vec_t               op2_q;
   vec_t               result_q;
   logic               err_q;
   logic               rsp_valid_q;
   logic               ready_q;
   logic [IDX_W-1:0]   k_q;

   logic [31:0]        mem [MEM_DEPTH];

   logic               accept;
   logic [31:0]        elem_a;
   logic [31:0]        elem_b;
   logic [31:0]        word_idx;
   logic               mem_in_range;
   logic [31:0]        mem_rdata;
   logic               mem_we;
   logic               last_elem;
   logic [31:0]        perm_sel;

   assign accept = ready_q && bus.vpu_req_i.valid;

   // Per-element datapath for the current index k.
   always_comb begin
      elem_a       = op1_q[k_q];
      elem_b       = op2_q[k_q];
      word_idx     = (addr_q >> 2) + 32'(k_q);
      mem_in_range = word_idx < 32'(MEM_DEPTH);
      mem_rdata    = mem[word_idx[MEM_AW-1:0]];
      mem_we       = (state == EXEC) && (opcode_q == OP_STORE) && mem_in_range;
      last_elem    = 32'(k_q) == (vl_q - 32'd1);
      perm_sel     = op1_q[elem_b[IDX_W-1:0]];
   end

   // Memory contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem[word_idx[MEM_AW-1:0]] <= elem_a;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         opcode_q    <= '0;
         vl_q        <= '0;
         addr_q      <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         ready_q     <= 1'b0;
         k_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  opcode_q <= bus.vpu_req_i.opcode;
                  vl_q     <= bus.vpu_req_i.vector_length;
                  addr_q   <= bus.vpu_req_i.addr;
                  op1_q    <= bus.vpu_req_i.operand1_vector;
                  op2_q    <= bus.vpu_req_i.operand2_vector;
                  result_q <= '0;
                  err_q    <= 1'b0;
                  k_q      <= '0;
                  ready_q  <= 1'b0;
                  // Malformed requests and empty vectors skip element processing.
                  if ((bus.vpu_req_i.opcode > OP_PERMUTE) ||
                      (bus.vpu_req_i.vector_length > 32'(MAX_VECTOR_LENGTH))) begin
                     err_q       <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end else if (bus.vpu_req_i.vector_length == 32'd0) begin
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end else begin
                     state <= EXEC;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end

            EXEC: begin
               case (opcode_q)
                  OP_ADD: result_q[k_q] <= elem_a + elem_b;
                  OP_SUB: result_q[k_q] <= elem_a - elem_b;
                  OP_MUL: result_q[k_q] <= elem_a * elem_b;
                  OP_DIV: begin
                     if (elem_b == 32'd0) begin
                        result_q[k_q] <= 32'hFFFF_FFFF;
                        err_q         <= 1'b1;
                     end else begin
                        result_q[k_q] <= elem_a / elem_b;
                     end
                  end
                  OP_LOAD: begin
                     if (mem_in_range) begin
                        result_q[k_q] <= mem_rdata;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
                  OP_STORE: begin
                     if (!mem_in_range) begin
                        err_q <= 1'b1;
                     end
                  end
                  OP_REDUCE_SUM: result_q[0] <= result_q[0] + elem_a;
                  OP_REDUCE_MIN: begin
                     if ((k_q == '0) || (elem_a < result_q[0])) begin
                        result_q[0] <= elem_a;
                     end
                  end
                  OP_REDUCE_MAX: begin
                     if ((k_q == '0) || (elem_a > result_q[0])) begin
                        result_q[0] <= elem_a;
                     end
                  end
                  OP_PERMUTE: begin
                     if (elem_b < vl_q) begin
                        result_q[k_q] <= perm_sel;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
                  default: ;
               endcase

               if (last_elem) begin
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  k_q <= k_q + IDX_W'(1);
               end
            end

            RESP: begin
               if (bus.vpu_rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.vpu_req_ready_o = ready_q;
   assign bus.vpu_rsp_o       = '{valid: rsp_valid_q, result_vector: result_q, error: err_q};

endmodule

// File: tb/tb_vpu_unit.sv
// Randomized scoreboard bench for vpu_unit with a behavioural reference model.
module tb_vpu_unit;
   import vpu_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vpu_unit_if bus ();

   vpu_unit #(.MEM_DEPTH(256)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned passed = 0;
   vpu_rsp_t    sb_q[$];
   logic [31:0] ref_mem [256];
   bit          bp_random = 1'b1;

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   function automatic vec_t v8(input logic [31:0] e0 = 32'd0, input logic [31:0] e1 = 32'd0,
                               input logic [31:0] e2 = 32'd0, input logic [31:0] e3 = 32'd0,
                               input logic [31:0] e4 = 32'd0, input logic [31:0] e5 = 32'd0,
                               input logic [31:0] e6 = 32'd0, input logic [31:0] e7 = 32'd0);
      vec_t v;
      v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
      v[4] = e4; v[5] = e5; v[6] = e6; v[7] = e7;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < 8; i++) v[i] = $urandom;
      return v;
   endfunction

   // Reference model: what the unit must answer, applying memory side effects in order.
   function automatic vpu_rsp_t model(input logic [3:0] op, input int unsigned vl,
                                      input logic [31:0] addr, input vec_t a, input vec_t b);
      vpu_rsp_t    r;
      int unsigned idx;
      logic [31:0] acc;
      r = '0;
      r.valid = 1'b1;
      if (op > 4'd9 || vl > 8) begin
         r.error = 1'b1;
         return r;
      end
      for (int i = 0; i < int'(vl); i++) begin
         idx = addr / 4 + i;
         case (op)
            4'd0: r.result_vector[i] = a[i] + b[i];
            4'd1: r.result_vector[i] = a[i] - b[i];
            4'd2: r.result_vector[i] = a[i] * b[i];
            4'd3: if (b[i] == 0) begin r.result_vector[i] = 32'hFFFF_FFFF; r.error = 1'b1; end
                  else r.result_vector[i] = a[i] / b[i];
            4'd4: if (idx >= 256) r.error = 1'b1; else r.result_vector[i] = ref_mem[idx];
            4'd5: if (idx >= 256) r.error = 1'b1; else ref_mem[idx] = a[i];
            4'd9: if (b[i] < vl) r.result_vector[i] = a[b[i]]; else r.error = 1'b1;
            default: ;
         endcase
      end
      if (vl > 0 && op >= 4'd6 && op <= 4'd8) begin
         acc = (op == 4'd6) ? 32'd0 : a[0];
         for (int i = 0; i < int'(vl); i++) begin
            if (op == 4'd6) acc = acc + a[i];
            else if (op == 4'd7 && a[i] < acc) acc = a[i];
            else if (op == 4'd8 && a[i] > acc) acc = a[i];
         end
         r.result_vector[0] = acc;
      end
      return r;
   endfunction

   task automatic issue(input logic [3:0] op, input int unsigned vl, input logic [31:0] addr,
                        input vec_t a, input vec_t b, input bit expect_rsp);
      vpu_req_t r;
      bit       acc = 1'b0;
      r.valid = 1'b1;
      r.opcode = op;
      r.vector_length = vl;
      r.addr = addr;
      r.operand1_vector = a;
      r.operand2_vector = b;
      @(posedge clk); #1;
      bus.vpu_req_i = r;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (bus.vpu_req_ready_o) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) check("accept", 1'b0, $sformatf("op %0d never accepted", op));
      else if (expect_rsp) sb_q.push_back(model(op, vl, addr, a, b));
      @(posedge clk); #1;
      // Scramble the request after accept; the unit must not resample it.
      r = '0;
      r.opcode = 4'($urandom);
      r.vector_length = $urandom;
      r.operand1_vector = rand_vec();
      r.operand2_vector = rand_vec();
      bus.vpu_req_i = r;
   endtask

   task automatic drain();
      bit empty = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            empty = 1'b1;
            break;
         end
      end
      if (!empty) check("drain", 1'b0, $sformatf("%0d responses outstanding", sb_q.size()));
   endtask

   // Monitor: compare every response handshake against the oldest expectation.
   initial begin
      vpu_rsp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.vpu_rsp_o.valid && bus.vpu_rsp_ready_i) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", 1'b0, $sformatf("got %h err %0b with nothing pending",
                     bus.vpu_rsp_o.result_vector, bus.vpu_rsp_o.error));
            end else begin
               e = sb_q.pop_front();
               check("rsp", {bus.vpu_rsp_o.result_vector, bus.vpu_rsp_o.error} ===
                            {e.result_vector, e.error},
                     $sformatf("got %h err %0b, want %h err %0b", bus.vpu_rsp_o.result_vector,
                               bus.vpu_rsp_o.error, e.result_vector, e.error));
            end
         end
      end
   end

   // Random consumer backpressure unless a directed test owns the ready line.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bp_random) bus.vpu_rsp_ready_i = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      vec_t        a, b;
      logic [3:0]  op;
      int unsigned vl;
      bit          seen;
      bus.vpu_req_i = '0;
      bus.vpu_rsp_ready_i = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", !bus.vpu_rsp_o.valid && bus.vpu_rsp_o.result_vector == '0 &&
            !bus.vpu_rsp_o.error && !bus.vpu_req_ready_o,
            $sformatf("valid %0b err %0b ready %0b", bus.vpu_rsp_o.valid, bus.vpu_rsp_o.error,
                      bus.vpu_req_ready_o));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("ready_after_reset", bus.vpu_req_ready_o == 1'b1,
            $sformatf("ready %0b want 1", bus.vpu_req_ready_o));

      // Give every memory word a known value.
      for (int w = 0; w < 256; w += 8) issue(OP_STORE, 8, 32'(w * 4), rand_vec(), '0, 1'b1);

      issue(OP_ADD, 4, 0, v8(1, 2, 3, 4), v8(5, 6, 7, 8), 1'b1);
      issue(OP_SUB, 4, 0, v8('hA, 'hB, 'hC, 'hD), v8(1, 2, 3, 4), 1'b1);
      issue(OP_MUL, 3, 0, v8(2, 3, 4), v8(5, 6, 7), 1'b1);
      issue(OP_DIV, 2, 0, v8('hA, 'hC), v8(2, 3), 1'b1);
      issue(OP_DIV, 2, 0, v8('hA, 'hC), v8(2, 0), 1'b1);
      issue(OP_STORE, 4, 'h100, v8('hAA, 'hBB, 'hCC, 'hDD), '0, 1'b1);
      issue(OP_LOAD, 4, 'h100, '0, '0, 1'b1);
      issue(OP_LOAD, 4, 'h103, '0, '0, 1'b1);
      issue(OP_REDUCE_SUM, 4, 0, v8(1, 2, 3, 4), '0, 1'b1);
      issue(OP_REDUCE_MIN, 5, 0, v8(5, 2, 8, 1, 9), '0, 1'b1);
      issue(OP_REDUCE_MAX, 3, 0, v8('h10, 5, 'h15), '0, 1'b1);
      issue(OP_PERMUTE, 4, 0, v8('hAA, 'hBB, 'hCC, 'hDD), v8(3, 1, 0, 2), 1'b1);
      issue(OP_PERMUTE, 4, 0, v8('hAA, 'hBB, 'hCC, 'hDD), v8(3, 4, 0, 2), 1'b1);
      issue(4'hF, 4, 0, rand_vec(), rand_vec(), 1'b1);
      issue(OP_ADD, 9, 0, rand_vec(), rand_vec(), 1'b1);
      issue(OP_ADD, 0, 0, rand_vec(), rand_vec(), 1'b1);
      issue(OP_STORE, 2, 'h3FC, v8('h11, 'h22), '0, 1'b1);
      issue(OP_LOAD, 2, 'h3FC, '0, '0, 1'b1);
      drain();

      // Held-off consumer: response and ready must stay put.
      @(posedge clk); #1;
      bp_random = 1'b0;
      bus.vpu_rsp_ready_i = 1'b0;
      issue(OP_ADD, 4, 0, v8(1, 2, 3, 4), v8(5, 6, 7, 8), 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus.vpu_rsp_o.valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("hold_rsp_valid", seen, "response never became valid");
      for (int c = 0; c < 5 && seen && sb_q.size() > 0; c++) begin
         @(negedge clk);
         check("hold_stable", bus.vpu_rsp_o.valid && !bus.vpu_req_ready_o &&
               {bus.vpu_rsp_o.result_vector, bus.vpu_rsp_o.error} ===
               {sb_q[0].result_vector, sb_q[0].error},
               $sformatf("valid %0b ready %0b result %h", bus.vpu_rsp_o.valid,
                         bus.vpu_req_ready_o, bus.vpu_rsp_o.result_vector));
      end
      @(posedge clk); #1;
      bus.vpu_rsp_ready_i = 1'b1;
      bp_random = 1'b1;
      drain();

      // Reset in the middle of a long operation aborts it without a response.
      issue(OP_REDUCE_SUM, 8, 0, rand_vec(), '0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort_valid", !bus.vpu_rsp_o.valid && !bus.vpu_req_ready_o,
            $sformatf("valid %0b ready %0b want 0/0", bus.vpu_rsp_o.valid, bus.vpu_req_ready_o));
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("abort_ready", bus.vpu_req_ready_o == 1'b1,
            $sformatf("ready %0b want 1", bus.vpu_req_ready_o));
      issue(OP_LOAD, 4, 'h100, '0, '0, 1'b1);

      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         vl = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 8);
         a  = rand_vec();
         for (int i = 0; i < 8; i++)
            b[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         issue(op, vl, 32'($urandom_range(0, 1100)), a, b, 1'b1);
      end
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vpu_unit.md
Name: vpu_unit

Overview:
- Multi-cycle vector processing unit attached to the core through a valid/ready request channel and a valid/ready response channel.
- Performs element-wise arithmetic, reductions, permutation, and load/store against a private word-addressed vector memory.
- Processes one element per cycle and returns a full result vector with an error flag.

Parameters:
- MAX_VECTOR_LENGTH, 8, number of 32-bit elements per vector register/port.
- MEM_DEPTH, 256, words of internal vector memory.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- vpu_req_i  in  vpu_req_t  request struct with these fields:
  - valid (1)
  - opcode (4)
  - vector_length (32, unsigned)
  - addr (32, byte address)
  - operand1_vector and operand2_vector (MAX_VECTOR_LENGTH x 32, element 0 first)
- vpu_req_ready_o  out  1  request accepted on a clock edge where valid && ready.
- vpu_rsp_o  out  vpu_rsp_t  response struct with these fields:
  - valid (1)
  - result_vector (MAX_VECTOR_LENGTH x 32)
  - error (1)
- vpu_rsp_ready_i  in  1  consumer accepts the response.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD, 5 STORE
  - 6 REDUCE_SUM, 7 REDUCE_MIN, 8 REDUCE_MAX, 9 PERMUTE
  - 10-15 unsupported.
- FSM states IDLE, EXEC, RESP.
- Reset: state IDLE, vpu_req_ready_o=1 after reset release (0 while rst_i high), rsp valid=0, result all zero, error=0. Memory is not reset.
- IDLE:
  - ready=1.
  - On accept, register opcode, vl, addr and both operand vectors, clear the result vector, set element index k=0, go to EXEC.
  - Request fields are not sampled after accept.
- Immediate errors (entry to EXEC, no memory writes, straight to RESP with error=1, result zero):
  - unsupported opcode;
  - vl > MAX_VECTOR_LENGTH.
- vl==0: go directly to RESP, result zero, error=0.
- EXEC: one element per cycle for k=0..vl-1; after element vl-1 go to RESP. Response valid the cycle after the last element edge.
- Per-element operations:
  - ADD/SUB/MUL: result[k] = low 32 bits of op1[k] +,-,* op2[k] (unsigned wrap).
  - DIV: unsigned op1[k]/op2[k]. If op2[k]==0, result[k]=32'hFFFFFFFF and the sticky error is set; processing continues.
  - STORE: mem[(addr>>2)+k] = op1[k]; result stays zero.
  - LOAD: result[k] = mem[(addr>>2)+k].
  - Word index >= MEM_DEPTH for LOAD or STORE: set error, skip that element's access (no write, result[k]=0).
  - addr[1:0] ignored.
  - REDUCE_SUM: accumulate a 32-bit wrap sum into result[0].
  - REDUCE_MIN/MAX: result[0] = unsigned min/max of op1[0..vl-1]; element 0 initialises.
  - Reductions: elements 1..MAX-1 are zero.
  - PERMUTE: result[k] = op1[op2[k]] if op2[k] < vl; else result[k]=0 and error set.
- Elements k >= vl of result are always zero.
- RESP:
  - rsp valid=1, result/error held stable, req ready=0.
  - When vpu_rsp_ready_i=1 at a clock edge, go to IDLE, valid=0.
  - A new request can be accepted the cycle after RESP exits, not in the same cycle.
- rst_i asserted mid-EXEC or mid-RESP: abort immediately to reset values. Memory writes already done persist; no partial response is issued.
- Back-to-back STORE then LOAD to the same address returns the stored data.

Test Plan:
- Arithmetic:
  - ADD vl=4: op1={1,2,3,4}, op2={5,6,7,8} -> result {6,8,10,12,0,0,0,0}, error 0.
  - SUB vl=4: {A,B,C,D}-{1,2,3,4} -> {9,9,9,9,0...}.
  - MUL vl=3: {2,3,4}*{5,6,7} -> {10,18,28,0...}.
- DIV:
  - vl=2: {A,C}/{2,3} -> {5,4,0...}, error 0.
  - {A,C}/{2,0} -> {5,FFFFFFFF,0...}, error 1.
- STORE/LOAD: STORE vl=4, addr 0x100, {AA,BB,CC,DD} -> error 0; then LOAD vl=4, addr 0x100 -> {AA,BB,CC,DD,0,0,0,0}; repeat the LOAD -> identical result.
- Reductions:
  - SUM of {1,2,3,4} -> result[0]=0000000A.
  - MIN of {5,2,8,1,9} -> 00000001.
  - MAX of {10,5,15} -> 00000015.
- PERMUTE: op1={AA,BB,CC,DD}, idx={3,1,0,2} -> {DD,BB,AA,CC,0...}, error 0; idx containing 4 with vl=4 -> that element 0, error 1.
- Errors and handshake:
  - opcode F -> error 1, result all zero.
  - vl=9 -> error 1.
  - Hold vpu_rsp_ready_i low 5 cycles -> response stable and req ready low.
  - Assert rst_i mid-EXEC -> rsp valid 0 immediately, ready 1 after release.
